// File: rtl/switch_box_config_loader_if.sv
// Config-stream handshake and committed-pattern bus between the fabric
// config master and one switch-box configuration loader.
interface switch_box_config_loader_if #(
    parameter int DW = 8,
    parameter int CW = 72
);
    logic          cfg_start;
    logic          cfg_abort;
    logic [DW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_last;
    logic          cfg_ready;
    logic [CW-1:0] c;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output cfg_start, cfg_abort, cfg_data, cfg_valid, cfg_last,
        input  cfg_ready, c, busy, done, err
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_data, cfg_valid, cfg_last,
        output cfg_ready, c, busy, done, err
    );
endinterface

// File: rtl/switch_box_config_loader.sv
// Assembles a word-serial configuration frame in a shadow register and commits
// it atomically to the switch box; malformed frames leave the committed pattern intact.
module switch_box_config_loader #(
    parameter int WS = 8,
    parameter int WD = 8,
    parameter int DW = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    switch_box_config_loader_if.slave  bus
);
    localparam int CW   = WS*6 + WD/2*6;
    localparam int NW   = (CW + DW - 1) / DW;
    localparam int CNTW = $clog2(NW) + 1;
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NW - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, ERROR} state_t;

    state_t             state;
    logic [CNTW-1:0]    count;
    logic [NW*DW-1:0]   shadow;
    logic [CW-1:0]      c_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic xfer;
    assign xfer = bus.cfg_valid && ready_q;

    // NOTE: every register here, the shadow included, is reset and assigned with
    // non-blocking <= only, so all outputs are flops with a defined post-reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            shadow  <= '0;
            c_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE, ERROR: begin
                    if (bus.cfg_start) begin
                        state   <= LOAD;
                        count   <= '0;
                        shadow  <= '0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (bus.cfg_abort) begin
                        state <= IDLE;
                    end
                end

                LOAD: begin
                    if (bus.cfg_abort) begin
                        state   <= IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (bus.cfg_start) begin
                        count  <= '0;
                        shadow <= '0;
                    end else if (xfer) begin
                        shadow[DW*count +: DW] <= bus.cfg_data;
                        if (bus.cfg_last && count == LAST_IDX) begin
                            state   <= COMMIT;
                            ready_q <= 1'b0;
                        end else if (bus.cfg_last || count == LAST_IDX) begin
                            // Short or long frame: drop it, keep the committed pattern.
                            state   <= ERROR;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end

                COMMIT: begin
                    c_q    <= shadow[CW-1:0];
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.c         = c_q;
    assign bus.cfg_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
